// File: rtl/recip_nr_pkg.sv
// Shared types and constants for the Newton-Raphson significand reciprocal.
// seed_val() builds the seed LUT and is usable by anything modelling the seed table.
package recip_nr_pkg;

  localparam int NSIG_DEF      = 7;
  localparam int GUARD_DEF     = 4;
  localparam int SEED_BITS_DEF = 4;
  localparam int NITER_DEF     = 2;
  localparam int FW            = NSIG_DEF + GUARD_DEF;

  typedef enum logic [2:0] {IDLE, SEED, MULA, MULB, DONE} state_t;

  // rne(1/(1+(i+0.5)/2^sbits)) in Q1.fw, done as round(2^(fw+sbits+1) / (2^(sbits+1)+2i+1))
  function automatic int seed_val(input int i, input int sbits, input int fw);
    longint num;
    longint den;
    longint q;
    longint rem;
    num = longint'(1) << (fw + sbits + 1);
    den = (longint'(1) << (sbits + 1)) + longint'(2 * i + 1);
    q   = num / den;
    rem = num % den;
    if ((2 * rem > den) || ((2 * rem == den) && q[0]))
      q = q + 1;
    return int'(q);
  endfunction

endpackage

// File: rtl/recip_nr_iter_mul.sv
// Shared (FW+1)x(FW+1) unsigned multiplier, Q1.FW in and out, optional clamp at 1.0.
module recip_nr_mul #(
  parameter int FW = 11
) (
  input  logic [FW:0] op_a,
  input  logic [FW:0] op_b,
  input  logic        sat,
  output logic [FW:0] prod
);

  localparam logic [FW+1:0] ONE = (FW+2)'(1) << FW;

  logic [2*FW+1:0] full;
  logic [FW+1:0]   trunc;

  assign full  = {{(FW+1){1'b0}}, op_a} * {{(FW+1){1'b0}}, op_b};
  // Q2.2FW product truncated to Q2.FW; the integer bit pair only matters for the clamp
  assign trunc = (FW+2)'(full >> FW);
  assign prod  = (sat && (trunc > ONE)) ? ONE[FW:0] : trunc[FW:0];

endmodule

// File: rtl/recip_nr_iter.sv
// Multi-cycle Newton-Raphson reciprocal R = 1/A of a Q1.NSIG significand.
// LUT seed, NITER refinements x = x*(2 - A*x) on one shared multiplier, RNE output.
module recip_nr_iter
  import recip_nr_pkg::*;
#(
  parameter int NEXP      = 8,
  parameter int NSIG      = 7,
  parameter int SEED_BITS = 4,
  parameter int NITER     = 2,
  parameter int GUARD     = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NSIG:0] a,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NSIG:0] r,
  output logic          out_err
);

  localparam int XW    = NSIG + GUARD;
  localparam int CNT_W = $clog2(NITER + 1);
  localparam logic [NSIG:0] ONE_R = {1'b1, {NSIG{1'b0}}};

  if (NITER < 1 || NEXP < 1 || GUARD < 2) begin : g_bad_param
    $error("recip_nr_iter: invalid parameter set");
  end

  state_t            state, state_next;
  logic [NSIG:0]     a_reg, a_next;
  logic [XW:0]       x_reg, x_next, t_reg, t_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [NSIG:0]     r_next;
  logic              err_next, in_ready_next, out_valid_next;
  logic [XW:0]       mul_a, mul_b, mul_out;
  logic              mul_sat;
  logic [NSIG+1:0]   r_sum;
  logic [NSIG:0]     r_round;
  logic              rnd_up;
  logic [XW:0]       seed_lut [2**SEED_BITS];

  for (genvar g = 0; g < 2**SEED_BITS; g++) begin : g_seed
    assign seed_lut[g] = (XW+1)'(seed_val(g, SEED_BITS, XW));
  end

  // MULA forms t = A*x; MULB forms x*(2-t) with the result clamped at 1.0
  always_comb begin
    mul_a   = {a_reg, {GUARD{1'b0}}};
    mul_b   = x_reg;
    mul_sat = 1'b0;
    if (state == MULB) begin
      mul_a   = x_reg;
      mul_b   = (XW+1)'(((XW+2)'(1) << (XW+1)) - (XW+2)'(t_reg));
      mul_sat = 1'b1;
    end
  end

  recip_nr_mul #(.FW(XW)) u_mul (
    .op_a (mul_a),
    .op_b (mul_b),
    .sat  (mul_sat),
    .prod (mul_out)
  );

  always_comb begin
    rnd_up  = mul_out[GUARD-1] && ((|mul_out[GUARD-2:0]) || mul_out[GUARD]);
    r_sum   = {1'b0, mul_out[XW:GUARD]} + (NSIG+2)'(rnd_up);
    r_round = (r_sum[NSIG+1] || (r_sum[NSIG:0] > ONE_R)) ? ONE_R : r_sum[NSIG:0];
  end

  always_comb begin
    state_next     = state;
    a_next         = a_reg;
    x_next         = x_reg;
    t_next         = t_reg;
    cnt_next       = cnt;
    r_next         = r;
    err_next       = out_err;
    in_ready_next  = in_ready;
    out_valid_next = out_valid;
    case (state)
      IDLE: begin
        in_ready_next = 1'b1;
        if (in_valid && in_ready) begin
          in_ready_next = 1'b0;
          a_next        = a;
          if (a == ONE_R) begin
            state_next     = DONE;
            r_next         = ONE_R;
            err_next       = 1'b0;
            out_valid_next = 1'b1;
          end else if (!a[NSIG]) begin
            state_next     = DONE;
            r_next         = '1;
            err_next       = 1'b1;
            out_valid_next = 1'b1;
          end else begin
            state_next = SEED;
          end
        end
      end
      SEED: begin
        x_next     = seed_lut[a_reg[NSIG-1 -: SEED_BITS]];
        cnt_next   = '0;
        state_next = MULA;
      end
      MULA: begin
        t_next     = mul_out;
        state_next = MULB;
      end
      MULB: begin
        x_next   = mul_out;
        cnt_next = cnt + CNT_W'(1);
        if (cnt == CNT_W'(NITER - 1)) begin
          state_next     = DONE;
          r_next         = r_round;
          err_next       = 1'b0;
          out_valid_next = 1'b1;
        end else begin
          state_next = MULA;
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          out_valid_next = 1'b0;
          in_ready_next  = 1'b1;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      x_reg     <= '0;
      t_reg     <= '0;
      cnt       <= '0;
      r         <= '0;
      out_err   <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      a_reg     <= a_next;
      x_reg     <= x_next;
      t_reg     <= t_next;
      cnt       <= cnt_next;
      r         <= r_next;
      out_err   <= err_next;
      in_ready  <= in_ready_next;
      out_valid <= out_valid_next;
    end
  end

endmodule

// File: tb/tb_recip_nr_iter.sv
// Directed bench for recip_nr_iter: fixed vectors, back-pressure, mid-run reset, full sweep.
module tb_recip_nr_iter;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] r;
  logic       out_err;

  int checks = 0;
  int passed = 0;

  recip_nr_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Offers val until accepted, then counts edges from the accept edge to out_valid
  task automatic apply_stimulus(input logic [7:0] val, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    a        = val;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check_output("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      lat      = -1;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 8'h00;
    lat      = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] val, input logic [7:0] exp_r,
                        input logic exp_err, input int exp_lat);
    int lat;
    out_ready = 1'b1;
    apply_stimulus(val, lat);
    check_output({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_output({tag, "_r"}, 32'(r), 32'(exp_r));
    check_output({tag, "_err"}, 32'(out_err), 32'(exp_err));
    @(posedge clk);
    #1;
    check_output({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check_output({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int hits;
    int diff;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = 8'h00;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_output("reset_in_ready", 32'(in_ready), 32'd0);
    check_output("reset_out_valid", 32'(out_valid), 32'd0);
    check_output("reset_r", 32'(r), 32'd0);
    check_output("reset_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("ready_after_reset", 32'(in_ready), 32'd1);

    $display("[TB] directed vectors");
    run_op("one", 8'h80, 8'h80, 1'b0, 1);
    run_op("x1p5", 8'hC0, 8'h55, 1'b0, 6);
    run_op("xff", 8'hFF, 8'h40, 1'b0, 6);
    run_op("x81", 8'h81, 8'h7F, 1'b0, 6);
    run_op("unnorm", 8'h7F, 8'hFF, 1'b1, 1);

    $display("[TB] back-pressure");
    out_ready = 1'b0;
    apply_stimulus(8'hC0, lat);
    check_output("bp_latency", 32'(lat), 32'd6);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a        = 8'h80;
      @(posedge clk);
      #1;
      check_output($sformatf("bp_r_%0d", i), 32'(r), 32'h55);
      check_output($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
      check_output($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_output("bp_valid_drop", 32'(out_valid), 32'd0);
    hits = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) hits++;
    end
    check_output("bp_no_second_capture", 32'(hits), 32'd0);

    $display("[TB] reset during MULA");
    @(negedge clk);
    in_valid = 1'b1;
    a        = 8'hC0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("abort_out_valid", 32'(out_valid), 32'd0);
    check_output("abort_in_ready", 32'(in_ready), 32'd0);
    check_output("abort_r", 32'(r), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hits  = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) hits++;
    end
    check_output("abort_no_stale", 32'(hits), 32'd0);
    check_output("abort_ready_back", 32'(in_ready), 32'd1);

    $display("[TB] sweep of normalised A");
    out_ready = 1'b1;
    for (int v = 128; v < 256; v++) begin
      apply_stimulus(8'(v), lat);
      // |r - 1/A| <= 1 ulp  <=>  |r*A - 2^14| <= A in integer units
      diff = int'(r) * v - 16384;
      if (diff < 0) diff = -diff;
      check_output($sformatf("sweep_a%0h_r%0h_within_ulp", v, r), 32'(diff <= v), 32'd1);
      check_output($sformatf("sweep_a%0h_err", v), 32'(out_err), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
